// File: rtl/toccata_pb_fifo.sv
// Playback byte FIFO between the Zorro register interface and the Toccata
// playback sequencer. Byte or word writes in, single bytes out, with
// level/empty/full flags and a half-empty refill interrupt.
// Optional sticky ovf/unf error flags are built when TOCCATA_FIFO_ERR_EN is defined.
module toccata_pb_fifo #(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned HALF_LVL = DEPTH / 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rst_fifo,
   input  logic                     wr_byte,
   input  logic                     wr_word,
   input  logic [15:0]              wr_data,
   output logic                     wr_busy,
   input  logic                     rd_en,
   output logic [7:0]               data_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     irq,
   input  logic                     irq_ack,
   output logic                     ovf,
   output logic                     unf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic {S_IDLE, S_LOW} wr_state_t;

   wr_state_t         state, state_nxt;
   logic [7:0]        mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [7:0]        stage_q;
   logic [7:0]        mem_wd;
   logic              mem_we;
   logic              rd_ok;
   logic              flush;
   logic              irq_set;
   logic [LW-1:0]     level_nxt;

   assign flush   = rst | rst_fifo;
   assign wr_busy = (state == S_LOW);
   assign rd_ok   = rd_en & ~empty & ~flush;

   // Word-write sequencer state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Write acceptance and word sequencing: high byte first, low byte staged
   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_wd    = wr_data[7:0];
      case (state)
         S_IDLE: begin
            if (wr_word) begin
               if (level <= LW'(DEPTH - 2)) begin
                  mem_we    = 1'b1;
                  mem_wd    = wr_data[15:8];
                  state_nxt = S_LOW;
               end
            end else if (wr_byte && !full) begin
               mem_we = 1'b1;
            end
         end
         S_LOW: begin
            mem_we    = 1'b1;
            mem_wd    = stage_q;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush) begin
         state_nxt = S_IDLE;
         mem_we    = 1'b0;
      end
   end

   // Hold the low byte of an accepted word for the second write cycle
   always_ff @(posedge clk) begin
      if (state == S_IDLE && state_nxt == S_LOW) stage_q <= wr_data[7:0];
   end

   // Byte storage, single write port
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr] <= mem_wd;
   end

   assign level_nxt = level + LW'(mem_we) - LW'(rd_ok);
   assign irq_set   = rd_ok && ((level > LW'(HALF_LVL) && level_nxt <= LW'(HALF_LVL))
                                || level_nxt == '0);

   // Pointers, level, flags, read data and refill interrupt
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         data_out <= 8'h00;
         irq      <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(mem_we);
         rd_ptr <= rd_ptr + AW'(rd_ok);
         level  <= level_nxt;
         empty  <= (level_nxt == '0);
         full   <= (level_nxt == LW'(DEPTH));
         if (rd_ok) data_out <= mem[rd_ptr];
         if (irq_set)      irq <= 1'b1;
         else if (irq_ack) irq <= 1'b0;
      end
   end

`ifdef TOCCATA_FIFO_ERR_EN
   logic wr_rej;
   logic rd_rej;

   assign wr_rej = (state == S_IDLE) &&
                   (wr_word ? (level > LW'(DEPTH - 2)) : (wr_byte && full));
   assign rd_rej = rd_en && empty;

   // Sticky error flags; a new error wins over a same-cycle acknowledge
   always_ff @(posedge clk) begin
      if (flush) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (wr_rej)       ovf <= 1'b1;
         else if (irq_ack) ovf <= 1'b0;
         if (rd_rej)       unf <= 1'b1;
         else if (irq_ack) unf <= 1'b0;
      end
   end
`else
   assign ovf = 1'b0;
   assign unf = 1'b0;
`endif

endmodule
